// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: tracked entry layout,
// default geometry and the forwarding select encoding.
package hazard_pkg;

    localparam int unsigned DEF_STAGES  = 4;
    localparam int unsigned DEF_ISSUE_W = 2;
    // Stored latency field width; LAT_W of the top must not exceed this.
    localparam int unsigned LAT_MAX_W   = 4;
    localparam logic [4:0]  REG_ZERO    = 5'd0;

    typedef struct packed {
        logic                 valid;
        logic [4:0]           wreg;
        logic [LAT_MAX_W-1:0] lat;
    } entry_t;

    function automatic int unsigned sel_encode(input int unsigned s, input int unsigned w,
                                               input int unsigned issue_w);
        return s * issue_w + w + 1;
    endfunction

    // Stage index of a non-zero select.
    function automatic int unsigned sel_stage(input int unsigned sel, input int unsigned issue_w);
        return (sel - 1) / issue_w;
    endfunction

endpackage

// File: rtl/hazard_fwd_pick.sv
// Picks the youngest tracked writer of one source operand and reports
// whether its result is not yet forwardable.
module hazard_fwd_pick
    import hazard_pkg::*;
#(
    parameter int unsigned STAGES  = DEF_STAGES,
    parameter int unsigned ISSUE_W = DEF_ISSUE_W,
    parameter int unsigned SEL_W   = $clog2(DEF_STAGES * DEF_ISSUE_W + 1)
) (
    input  logic [4:0]                     src,
    input  logic                           rd,
    input  entry_t [STAGES*ISSUE_W-1:0]    entries,
    output logic [SEL_W-1:0]               sel,
    output logic                           not_ready
);

    int lat_eff;

    // Scan oldest to youngest so the last hit (lowest stage, highest slot) wins.
    always_comb begin
        sel       = '0;
        not_ready = 1'b0;
        lat_eff   = 0;
        if (rd && src != REG_ZERO) begin
            for (int s = int'(STAGES) - 1; s >= 0; s--) begin
                for (int w = 0; w < int'(ISSUE_W); w++) begin
                    if (entries[s*int'(ISSUE_W)+w].valid &&
                        entries[s*int'(ISSUE_W)+w].wreg == src) begin
                        lat_eff = int'(entries[s*int'(ISSUE_W)+w].lat);
                        if (lat_eff > int'(STAGES) - 1) lat_eff = int'(STAGES) - 1;
                        sel       = SEL_W'(sel_encode(unsigned'(s), unsigned'(w), ISSUE_W));
                        not_ready = (s < lat_eff);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tag-pipeline hazard scoreboard: forwarding selects, pipe/intra-group stalls
// and in-order partial-issue masks. HAZ_PERF_CNT_EN adds stall/split counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned ISSUE_W = DEF_ISSUE_W,
    parameter int unsigned STAGES  = DEF_STAGES,
    parameter int unsigned LAT_W   = 2,
    parameter int unsigned SEL_W   = $clog2(STAGES * ISSUE_W + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_adv,
    input  logic                       flush_all,
    input  logic                       flush_young,
    input  logic [ISSUE_W-1:0]         dec_valid,
    input  logic [5*ISSUE_W-1:0]       dec_rs,
    input  logic [5*ISSUE_W-1:0]       dec_rt,
    input  logic [ISSUE_W-1:0]         dec_read_rs,
    input  logic [ISSUE_W-1:0]         dec_read_rt,
    input  logic [ISSUE_W-1:0]         dec_wr,
    input  logic [5*ISSUE_W-1:0]       dec_wreg,
    input  logic [LAT_W*ISSUE_W-1:0]   dec_lat,
    output logic [ISSUE_W-1:0]         issue_mask,
    output logic                       stall_dec,
    output logic [SEL_W*ISSUE_W-1:0]   fwd_rs_sel,
    output logic [SEL_W*ISSUE_W-1:0]   fwd_rt_sel
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                split_groups
`endif
);

    localparam int unsigned N = STAGES * ISSUE_W;

    entry_t [N-1:0]     entries_q;
    logic [ISSUE_W-1:0] rs_nr, rt_nr, intra_dep, blocked;

    for (genvar w = 0; w < int'(ISSUE_W); w++) begin : g_pick
        hazard_fwd_pick #(.STAGES(STAGES), .ISSUE_W(ISSUE_W), .SEL_W(SEL_W)) u_rs (
            .src       (dec_rs[5*w+:5]),
            .rd        (dec_read_rs[w]),
            .entries   (entries_q),
            .sel       (fwd_rs_sel[SEL_W*w+:SEL_W]),
            .not_ready (rs_nr[w])
        );
        hazard_fwd_pick #(.STAGES(STAGES), .ISSUE_W(ISSUE_W), .SEL_W(SEL_W)) u_rt (
            .src       (dec_rt[5*w+:5]),
            .rd        (dec_read_rt[w]),
            .entries   (entries_q),
            .sel       (fwd_rt_sel[SEL_W*w+:SEL_W]),
            .not_ready (rt_nr[w])
        );
    end

    // A slot depending on an older slot of the same group never co-issues with it.
    always_comb begin
        intra_dep = '0;
        for (int j = 1; j < int'(ISSUE_W); j++) begin
            for (int i = 0; i < j; i++) begin
                if (dec_valid[i] && dec_wr[i]) begin
                    if ((dec_read_rs[j] && dec_rs[5*j+:5] != REG_ZERO &&
                         dec_rs[5*j+:5] == dec_wreg[5*i+:5]) ||
                        (dec_read_rt[j] && dec_rt[5*j+:5] != REG_ZERO &&
                         dec_rt[5*j+:5] == dec_wreg[5*i+:5])) begin
                        intra_dep[j] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        logic ok;
        blocked = rs_nr | rt_nr | intra_dep;
        ok      = 1'b1;
        for (int j = 0; j < int'(ISSUE_W); j++) begin
            if (blocked[j]) ok = 1'b0;
            issue_mask[j] = dec_valid[j] & ok;
        end
    end

    assign stall_dec = ~issue_mask[0] & dec_valid[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '0;
        end else if (flush_all) begin
            entries_q <= '0;
        end else if (pipe_adv) begin
            for (int s = int'(STAGES) - 2; s >= 0; s--) begin
                for (int w = 0; w < int'(ISSUE_W); w++) begin
                    entries_q[(s+1)*int'(ISSUE_W)+w] <= entries_q[s*int'(ISSUE_W)+w];
                end
            end
            for (int w = 0; w < int'(ISSUE_W); w++) begin
                entries_q[w].valid <= dec_valid[w] & issue_mask[w] & dec_wr[w] & ~flush_young;
                entries_q[w].wreg  <= dec_wreg[5*w+:5];
                entries_q[w].lat   <= LAT_MAX_W'(dec_lat[LAT_W*w+:LAT_W]);
            end
        end else if (flush_young) begin
            for (int w = 0; w < int'(ISSUE_W); w++) entries_q[w].valid <= 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            split_groups <= '0;
        end else if (pipe_adv) begin
            if (stall_dec) stall_cycles <= stall_cycles + 32'd1;
            if (issue_mask != dec_valid && issue_mask != '0) split_groups <= split_groups + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (ISSUE_W=2, STAGES=4).
module tb_hazard_scoreboard;

    localparam int unsigned ISSUE_W = 2;
    localparam int unsigned STAGES  = 4;
    localparam int unsigned LAT_W   = 2;
    localparam int unsigned SEL_W   = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     pipe_adv, flush_all, flush_young;
    logic [ISSUE_W-1:0]       dec_valid, dec_read_rs, dec_read_rt, dec_wr;
    logic [5*ISSUE_W-1:0]     dec_rs, dec_rt, dec_wreg;
    logic [LAT_W*ISSUE_W-1:0] dec_lat;
    logic [ISSUE_W-1:0]       issue_mask;
    logic                     stall_dec;
    logic [SEL_W*ISSUE_W-1:0] fwd_rs_sel, fwd_rt_sel;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]              stall_cycles, split_groups;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.ISSUE_W(ISSUE_W), .STAGES(STAGES), .LAT_W(LAT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_adv    (pipe_adv),
        .flush_all   (flush_all),
        .flush_young (flush_young),
        .dec_valid   (dec_valid),
        .dec_rs      (dec_rs),
        .dec_rt      (dec_rt),
        .dec_read_rs (dec_read_rs),
        .dec_read_rt (dec_read_rt),
        .dec_wr      (dec_wr),
        .dec_wreg    (dec_wreg),
        .dec_lat     (dec_lat),
        .issue_mask  (issue_mask),
        .stall_dec   (stall_dec),
        .fwd_rs_sel  (fwd_rs_sel),
        .fwd_rt_sel  (fwd_rt_sel)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .split_groups (split_groups)
`endif
    );

    task automatic clear_dec;
        pipe_adv = 0; flush_all = 0; flush_young = 0;
        dec_valid = '0; dec_read_rs = '0; dec_read_rt = '0; dec_wr = '0;
        dec_rs = '0; dec_rt = '0; dec_wreg = '0; dec_lat = '0;
    endtask

    task automatic set_slot(input int w, input logic [4:0] rs, input logic rrs,
                            input logic [4:0] rt, input logic rrt,
                            input logic wr, input logic [4:0] wreg, input logic [1:0] lat);
        dec_valid[w] = 1'b1;
        dec_rs[5*w+:5] = rs;  dec_read_rs[w] = rrs;
        dec_rt[5*w+:5] = rt;  dec_read_rt[w] = rrt;
        dec_wr[w] = wr; dec_wreg[5*w+:5] = wreg; dec_lat[2*w+:2] = lat;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic flush_pipe;
        clear_dec();
        flush_all = 1;
        tick();
        clear_dec();
    endtask

    task automatic test_reset;
        clear_dec();
        set_slot(0, 5'd3, 1, 5'd4, 1, 1, 5'd6, 2'd0);
        set_slot(1, 5'd3, 1, 5'd8, 1, 0, 5'd0, 2'd0);
        #1;
        checks++; if (issue_mask !== 2'b11) begin errors++;
            $display("FAIL reset_mask got %b want 11", issue_mask); end
        checks++; if (stall_dec !== 1'b0) begin errors++;
            $display("FAIL reset_stall got %b want 0", stall_dec); end
        checks++; if (fwd_rs_sel !== 8'h00) begin errors++;
            $display("FAIL reset_rs_sel got %h want 00", fwd_rs_sel); end
        checks++; if (fwd_rt_sel !== 8'h00) begin errors++;
            $display("FAIL reset_rt_sel got %h want 00", fwd_rt_sel); end
    endtask

    task automatic test_alu_chain;
        flush_pipe();
        set_slot(0, 5'd1, 1, 5'd2, 1, 1, 5'd3, 2'd0);
        pipe_adv = 1; #1;
        checks++; if (issue_mask !== 2'b01) begin errors++;
            $display("FAIL alu_first_mask got %b want 01", issue_mask); end
        tick(); clear_dec();
        set_slot(0, 5'd3, 1, 5'd0, 0, 0, 5'd0, 2'd0);
        set_slot(1, 5'd0, 0, 5'd3, 1, 0, 5'd0, 2'd0);
        pipe_adv = 1; #1;
        checks++; if (fwd_rs_sel[3:0] !== 4'd1) begin errors++;
            $display("FAIL alu_rs0_sel got %0d want 1", fwd_rs_sel[3:0]); end
        checks++; if (fwd_rt_sel[7:4] !== 4'd1) begin errors++;
            $display("FAIL alu_rt1_sel got %0d want 1", fwd_rt_sel[7:4]); end
        checks++; if (issue_mask !== 2'b11) begin errors++;
            $display("FAIL alu_mask got %b want 11", issue_mask); end
        tick(); #1;
        checks++; if (fwd_rs_sel[3:0] !== 4'd3) begin errors++;
            $display("FAIL alu_m_stage_sel got %0d want 3", fwd_rs_sel[3:0]); end
    endtask

    task automatic test_load_use;
        flush_pipe();
        set_slot(0, 5'd1, 1, 5'd0, 0, 1, 5'd5, 2'd1);
        pipe_adv = 1; tick(); clear_dec();
        set_slot(0, 5'd5, 1, 5'd0, 0, 0, 5'd0, 2'd0);
        set_slot(1, 5'd2, 1, 5'd0, 0, 0, 5'd0, 2'd0);
        #1;
        checks++; if (stall_dec !== 1'b1) begin errors++;
            $display("FAIL load_use_stall got %b want 1", stall_dec); end
        checks++; if (issue_mask !== 2'b00) begin errors++;
            $display("FAIL load_use_mask got %b want 00", issue_mask); end
        tick(); // no pipe_adv: rows hold
        checks++; if (stall_dec !== 1'b1) begin errors++;
            $display("FAIL load_use_hold_stall got %b want 1", stall_dec); end
        pipe_adv = 1; tick(); #1;
        checks++; if (fwd_rs_sel[3:0] !== 4'd3) begin errors++;
            $display("FAIL load_use_sel got %0d want 3", fwd_rs_sel[3:0]); end
        checks++; if (stall_dec !== 1'b0) begin errors++;
            $display("FAIL load_use_release got %b want 0", stall_dec); end
        checks++; if (issue_mask !== 2'b11) begin errors++;
            $display("FAIL load_use_mask2 got %b want 11", issue_mask); end
    endtask

    task automatic test_intra_group;
        flush_pipe();
        set_slot(0, 5'd1, 1, 5'd2, 1, 1, 5'd7, 2'd0);
        set_slot(1, 5'd7, 1, 5'd0, 0, 1, 5'd8, 2'd0);
        pipe_adv = 1; #1;
        checks++; if (issue_mask !== 2'b01) begin errors++;
            $display("FAIL intra_mask got %b want 01", issue_mask); end
        dec_read_rs[1] = 0; dec_rt[9:5] = 5'd7; #1;
        checks++; if (issue_mask !== 2'b11) begin errors++;
            $display("FAIL intra_unread_mask got %b want 11", issue_mask); end
        dec_read_rs[1] = 1; dec_wreg[4:0] = 5'd0; dec_rs[9:5] = 5'd0; #1;
        checks++; if (issue_mask !== 2'b11) begin errors++;
            $display("FAIL intra_r0_mask got %b want 11", issue_mask); end
        dec_wreg[4:0] = 5'd7; dec_rs[9:5] = 5'd7; #1;
        tick(); clear_dec();
        set_slot(0, 5'd7, 1, 5'd0, 0, 1, 5'd8, 2'd0);
        #1;
        checks++; if (fwd_rs_sel[3:0] !== 4'd1) begin errors++;
            $display("FAIL intra_replay_sel got %0d want 1", fwd_rs_sel[3:0]); end
        checks++; if (issue_mask !== 2'b01) begin errors++;
            $display("FAIL intra_replay_mask got %b want 01", issue_mask); end
    endtask

    task automatic test_priority;
        flush_pipe();
        set_slot(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 2'd0);
        set_slot(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 2'd0);
        pipe_adv = 1; tick(); clear_dec();
        set_slot(0, 5'd0, 0, 5'd0, 0, 1, 5'd9, 2'd0);
        set_slot(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 2'd0);
        pipe_adv = 1; tick(); clear_dec();
        set_slot(0, 5'd9, 1, 5'd0, 1, 1, 5'd10, 2'd0);
        set_slot(1, 5'd0, 0, 5'd0, 0, 1, 5'd10, 2'd0);
        pipe_adv = 1; #1;
        checks++; if (fwd_rs_sel[3:0] !== 4'd1) begin errors++;
            $display("FAIL prio_youngest got %0d want 1", fwd_rs_sel[3:0]); end
        checks++; if (fwd_rt_sel[3:0] !== 4'd0) begin errors++;
            $display("FAIL prio_r0 got %0d want 0", fwd_rt_sel[3:0]); end
        checks++; if (issue_mask !== 2'b11) begin errors++;
            $display("FAIL prio_mask got %b want 11", issue_mask); end
        tick(); clear_dec();
        set_slot(0, 5'd10, 1, 5'd9, 1, 0, 5'd0, 2'd0);
        #1;
        checks++; if (fwd_rs_sel[3:0] !== 4'd2) begin errors++;
            $display("FAIL prio_same_row got %0d want 2", fwd_rs_sel[3:0]); end
        checks++; if (fwd_rt_sel[3:0] !== 4'd3) begin errors++;
            $display("FAIL prio_stage1 got %0d want 3", fwd_rt_sel[3:0]); end
    endtask

    task automatic test_flush;
        flush_pipe();
        set_slot(0, 5'd0, 0, 5'd0, 0, 1, 5'd4, 2'd0);
        pipe_adv = 1; tick(); clear_dec();
        set_slot(0, 5'd0, 0, 5'd0, 0, 1, 5'd6, 2'd0);
        pipe_adv = 1; flush_all = 1; tick(); clear_dec();
        set_slot(0, 5'd4, 1, 5'd6, 1, 0, 5'd0, 2'd0);
        #1;
        checks++; if (fwd_rs_sel[3:0] !== 4'd0) begin errors++;
            $display("FAIL flush_all_old got %0d want 0", fwd_rs_sel[3:0]); end
        checks++; if (fwd_rt_sel[3:0] !== 4'd0) begin errors++;
            $display("FAIL flush_all_new got %0d want 0", fwd_rt_sel[3:0]); end
        clear_dec();
        set_slot(0, 5'd0, 0, 5'd0, 0, 1, 5'd11, 2'd0);
        pipe_adv = 1; tick();
        dec_wreg[4:0] = 5'd12; tick(); clear_dec();
        flush_young = 1; tick(); clear_dec();
        set_slot(0, 5'd12, 1, 5'd11, 1, 0, 5'd0, 2'd0);
        #1;
        checks++; if (fwd_rs_sel[3:0] !== 4'd0) begin errors++;
            $display("FAIL flush_young_row0 got %0d want 0", fwd_rs_sel[3:0]); end
        checks++; if (fwd_rt_sel[3:0] !== 4'd3) begin errors++;
            $display("FAIL flush_young_row1 got %0d want 3", fwd_rt_sel[3:0]); end
        clear_dec();
        set_slot(0, 5'd0, 0, 5'd0, 0, 1, 5'd13, 2'd0);
        pipe_adv = 1; flush_young = 1; tick(); clear_dec();
        set_slot(0, 5'd13, 1, 5'd11, 1, 0, 5'd0, 2'd0);
        #1;
        checks++; if (fwd_rs_sel[3:0] !== 4'd0) begin errors++;
            $display("FAIL flush_young_adv_ins got %0d want 0", fwd_rs_sel[3:0]); end
        checks++; if (fwd_rt_sel[3:0] !== 4'd5) begin errors++;
            $display("FAIL flush_young_adv_shift got %0d want 5", fwd_rt_sel[3:0]); end
    endtask

    task automatic test_async_reset;
        flush_pipe();
        set_slot(0, 5'd0, 0, 5'd0, 0, 1, 5'd20, 2'd0);
        set_slot(1, 5'd0, 0, 5'd0, 0, 1, 5'd21, 2'd0);
        pipe_adv = 1;
        for (int i = 0; i < 4; i++) tick();
        clear_dec();
        set_slot(0, 5'd20, 1, 5'd21, 1, 0, 5'd0, 2'd0);
        #1;
        checks++; if (fwd_rs_sel[3:0] !== 4'd1) begin errors++;
            $display("FAIL async_pre got %0d want 1", fwd_rs_sel[3:0]); end
        rst = 1; #1;
        checks++; if (fwd_rs_sel[3:0] !== 4'd0) begin errors++;
            $display("FAIL async_rs got %0d want 0", fwd_rs_sel[3:0]); end
        checks++; if (fwd_rt_sel[3:0] !== 4'd0) begin errors++;
            $display("FAIL async_rt got %0d want 0", fwd_rt_sel[3:0]); end
`ifdef HAZ_PERF_CNT_EN
        checks++; if (stall_cycles !== 32'd0) begin errors++;
            $display("FAIL async_stall_cnt got %0d want 0", stall_cycles); end
        checks++; if (split_groups !== 32'd0) begin errors++;
            $display("FAIL async_split_cnt got %0d want 0", split_groups); end
`endif
        clear_dec();
        #1 rst = 0;
        #1;
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf;
        clear_dec();
        set_slot(0, 5'd0, 0, 5'd0, 0, 1, 5'd5, 2'd1);
        pipe_adv = 1; tick(); clear_dec();
        set_slot(0, 5'd5, 1, 5'd0, 0, 0, 5'd0, 2'd0);
        set_slot(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 2'd0);
        pipe_adv = 1; tick(); clear_dec();
        set_slot(0, 5'd0, 0, 5'd0, 0, 1, 5'd7, 2'd0);
        set_slot(1, 5'd7, 1, 5'd0, 0, 0, 5'd0, 2'd0);
        pipe_adv = 1; tick(); clear_dec();
        checks++; if (stall_cycles !== 32'd1) begin errors++;
            $display("FAIL perf_stall got %0d want 1", stall_cycles); end
        checks++; if (split_groups !== 32'd1) begin errors++;
            $display("FAIL perf_split got %0d want 1", split_groups); end
    endtask
`endif

    initial begin
        clear_dec();
        rst = 1;
        #12 rst = 0;
        #1;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_intra_group();
        test_priority();
        test_flush();
        test_async_reset();
`ifdef HAZ_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
